// File: rtl/mem_port_arbiter.sv
// Shares a single backing-memory request channel between instruction fetch (I)
// and load/store (D). One transaction in flight; D has priority unless I has
// been passed over STARVE_LIMIT consecutive times. Also produces the core stall.
module mem_port_arbiter #(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_req,
    input  logic [AWIDTH-1:0]     i_addr,
    output logic [DWIDTH-1:0]     i_rdata,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic [AWIDTH-1:0]     d_addr,
    input  logic [DWIDTH/8-1:0]   d_we,
    input  logic [DWIDTH-1:0]     d_wdata,
    output logic [DWIDTH-1:0]     d_rdata,
    output logic                  d_done,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [AWIDTH-1:0]     mem_req_addr,
    output logic [DWIDTH/8-1:0]   mem_req_we,
    output logic [DWIDTH-1:0]     mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DWIDTH-1:0]     mem_resp_data,
    output logic                  stall
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [1:0]          state_q, state_d;
    logic                owner_d_q, owner_d_d;   // 1 = transaction belongs to D
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [DWIDTH/8-1:0] we_q, we_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]          starve_q, starve_d;
    logic [DWIDTH-1:0]   i_rdata_q, i_rdata_d;
    logic [DWIDTH-1:0]   d_rdata_q, d_rdata_d;
    logic                i_done_q, i_done_d;
    logic                d_done_q, d_done_d;

    logic                grant_d;
    logic                grant_ok;
    logic                resp_fire;

    // D wins unless I is pending and has already been passed over the limit.
    // No grant during a done cycle: the requester gets that cycle to drop or
    // change its request, and arbitration happens in the following IDLE cycle.
    assign grant_d   = d_req && !(i_req && (starve_q == STARVE_MAX));
    assign grant_ok  = (state_q == ST_IDLE) && !i_done_q && !d_done_q && (i_req || d_req);
    assign resp_fire = (state_q == ST_WAIT) && mem_resp_valid;

    // Transaction FSM: latch the winner in IDLE, present it in ISSUE, await response in WAIT.
    always_comb begin
        state_d   = state_q;
        owner_d_d = owner_d_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_ok) begin
                    state_d   = ST_ISSUE;
                    owner_d_d = grant_d;
                    if (grant_d) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                    end else begin
                        addr_d  = i_addr;
                        we_d    = '0;
                        wdata_d = '0;
                    end
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_resp_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Starvation counter: counts D grants that bypass a waiting I, saturating at the limit.
    always_comb begin
        starve_d = starve_q;
        if (!i_req) begin
            starve_d = '0;
        end else if (grant_ok) begin
            if (grant_d) begin
                if (starve_q < STARVE_MAX) starve_d = starve_q + 4'd1;
            end else begin
                starve_d = '0;
            end
        end
    end

    // Completion: one-cycle done pulse to the owner; read data held until its next done.
    always_comb begin
        i_done_d  = resp_fire && !owner_d_q;
        d_done_d  = resp_fire &&  owner_d_q;
        i_rdata_d = i_done_d ? mem_resp_data : i_rdata_q;
        d_rdata_d = d_done_d ? mem_resp_data : d_rdata_q;
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            owner_d_q <= 1'b0;
            addr_q    <= '0;
            we_q      <= '0;
            wdata_q   <= '0;
            starve_q  <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_d_q <= owner_d_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            starve_q  <= starve_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
        end
    end

    assign mem_req_valid = (state_q == ST_ISSUE);
    assign mem_req_addr  = addr_q;
    assign mem_req_we    = we_q;
    assign mem_req_wdata = wdata_q;
    assign i_done        = i_done_q;
    assign d_done        = d_done_q;
    assign i_rdata       = i_rdata_q;
    assign d_rdata       = d_rdata_q;
    assign stall         = (i_req & ~i_done_q) | (d_req & ~d_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven and outputs sampled on the
// falling edge; the memory side is played by the tasks below.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_we;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .stall(stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory stand-in: waits (bounded) for a request, accepts it, responds next cycle.
    // Returns at the falling edge of the done cycle.
    task automatic mem_serve(input logic [31:0] rd, output logic [31:0] a,
                             output logic [3:0] we, output logic [31:0] wd, output logic ok);
        ok = 1'b0; a = '0; we = '0; wd = '0;
        for (int n = 0; n < 20; n++) begin
            if (mem_req_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) begin
            a = mem_req_addr; we = mem_req_we; wd = mem_req_wdata;
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            mem_resp_data  = rd;
            @(negedge clk);
            mem_resp_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_addr = 0; d_we = 0; d_wdata = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
        #1;
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", mem_req_valid); end
        n_checks++; if (mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", mem_req_addr); end
        n_checks++; if ({i_done, d_done} !== 2'b00) begin n_fail++; $display("FAIL rst_done: got %b expected 00", {i_done, d_done}); end
        n_checks++; if ({i_rdata, d_rdata} !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", {i_rdata, d_rdata}); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b expected 0", stall); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Single fetch with immediate ready and response one cycle later.
    task automatic test_single_fetch(input string tag);
        i_req = 1'b1; i_addr = 32'h0000_1000; mem_req_ready = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL %s_stall_c0: got %b expected 1", tag, stall); end
        @(negedge clk);
        n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000 || mem_req_we !== 4'h0)
            begin n_fail++; $display("FAIL %s_issue: got v=%b a=%h we=%h expected v=1 a=1000 we=0", tag, mem_req_valid, mem_req_addr, mem_req_we); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL %s_stall_c1: got %b expected 1", tag, stall); end
        @(negedge clk);
        mem_req_ready = 1'b0;
        n_checks++; if (mem_req_valid !== 1'b0 || i_done !== 1'b0 || stall !== 1'b1)
            begin n_fail++; $display("FAIL %s_wait: got v=%b done=%b stall=%b expected 0 0 1", tag, mem_req_valid, i_done, stall); end
        mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        n_checks++; if (i_done !== 1'b1 || d_done !== 1'b0) begin n_fail++; $display("FAIL %s_done_c3: got i=%b d=%b expected i=1 d=0", tag, i_done, d_done); end
        n_checks++; if (i_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL %s_rdata: got %h expected deadbeef", tag, i_rdata); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL %s_stall_done: got %b expected 0", tag, stall); end
        i_req = 1'b0;
        @(negedge clk);
        n_checks++; if (i_done !== 1'b0 || mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL %s_after: got done=%b v=%b expected 0 0", tag, i_done, mem_req_valid); end
    endtask

    task automatic test_d_priority;
        logic [31:0] a, wd; logic [3:0] we; logic ok;
        i_req = 1'b1; i_addr = 32'h2000;
        d_req = 1'b1; d_addr = 32'h3000; d_we = 4'b0011; d_wdata = 32'h0000_55AA;
        mem_serve(32'h0000_0BAD, a, we, wd, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL prio_timeout1: got %b expected 1", ok); end
        n_checks++; if (a !== 32'h3000 || we !== 4'b0011 || wd !== 32'h55AA)
            begin n_fail++; $display("FAIL prio_first: got a=%h we=%b wd=%h expected a=3000 we=0011 wd=55aa", a, we, wd); end
        n_checks++; if (d_done !== 1'b1 || i_done !== 1'b0) begin n_fail++; $display("FAIL prio_ddone: got d=%b i=%b expected d=1 i=0", d_done, i_done); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL prio_stall: got %b expected 1", stall); end
        d_req = 1'b0; d_we = 4'h0;
        mem_serve(32'h1234_5678, a, we, wd, ok);
        n_checks++; if (ok !== 1'b1 || a !== 32'h2000 || we !== 4'h0)
            begin n_fail++; $display("FAIL prio_second: got ok=%b a=%h we=%h expected ok=1 a=2000 we=0", ok, a, we); end
        n_checks++; if (i_done !== 1'b1 || i_rdata !== 32'h1234_5678)
            begin n_fail++; $display("FAIL prio_idone: got done=%b rdata=%h expected 1 12345678", i_done, i_rdata); end
        i_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_starvation;
        logic [31:0] a, wd; logic [3:0] we; logic ok;
        logic [31:0] exp_a [6] = '{32'h5000, 32'h5004, 32'h5008, 32'h500C, 32'h4000, 32'h5010};
        logic        exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int dcount = 0;
        i_req = 1'b1; i_addr = 32'h4000;
        d_req = 1'b1; d_addr = 32'h5000; d_we = 4'h0; d_wdata = 32'h0;
        for (int k = 0; k < 6; k++) begin
            mem_serve(32'hA0 + k, a, we, wd, ok);
            n_checks++; if (ok !== 1'b1 || a !== exp_a[k])
                begin n_fail++; $display("FAIL starve_grant%0d: got ok=%b a=%h expected ok=1 a=%h", k, ok, a, exp_a[k]); end
            n_checks++; if ({d_done, i_done} !== {exp_d[k], ~exp_d[k]})
                begin n_fail++; $display("FAIL starve_done%0d: got d=%b i=%b expected d=%b", k, d_done, i_done, exp_d[k]); end
            n_checks++; if ((exp_d[k] ? d_rdata : i_rdata) !== 32'hA0 + k)
                begin n_fail++; $display("FAIL starve_rdata%0d: got %h expected %h", k, exp_d[k] ? d_rdata : i_rdata, 32'hA0 + k); end
            if (exp_d[k]) begin dcount++; d_addr = 32'h5000 + 4 * dcount; end
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ready_hold;
        logic ok = 1'b0;
        d_req = 1'b1; d_addr = 32'h6000; d_we = 4'b1100; d_wdata = 32'h1111_2222; mem_req_ready = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (mem_req_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL hold_timeout: got %b expected 1", ok); end
        for (int c = 0; c < 6; c++) begin
            n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h6000 || mem_req_we !== 4'b1100 || mem_req_wdata !== 32'h1111_2222)
                begin n_fail++; $display("FAIL hold_c%0d: got v=%b a=%h we=%b wd=%h expected v=1 a=6000 we=1100 wd=11112222", c, mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata); end
            if (c == 0) begin d_addr = 32'h7777; d_we = 4'hF; d_wdata = 32'h9999_9999; end
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h66;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        n_checks++; if (d_done !== 1'b1 || d_rdata !== 32'h66) begin n_fail++; $display("FAIL hold_done: got done=%b rdata=%h expected 1 66", d_done, d_rdata); end
        d_req = 1'b0; d_we = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_spurious_resp;
        logic [31:0] a, wd; logic [3:0] we; logic ok;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hFFFF_FFFF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if ({i_done, d_done, mem_req_valid} !== 3'b000)
                begin n_fail++; $display("FAIL spur_c%0d: got i=%b d=%b v=%b expected 000", c, i_done, d_done, mem_req_valid); end
        end
        mem_resp_valid = 1'b0;
        n_checks++; if (d_rdata !== 32'h66 || i_rdata !== 32'hA4)
            begin n_fail++; $display("FAIL spur_rdata: got d=%h i=%h expected d=66 i=a4", d_rdata, i_rdata); end
        i_req = 1'b1; i_addr = 32'h9000;
        @(negedge clk);
        n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h9000)
            begin n_fail++; $display("FAIL spur_idle: got v=%b a=%h expected v=1 a=9000", mem_req_valid, mem_req_addr); end
        mem_serve(32'h99, a, we, wd, ok);
        n_checks++; if (ok !== 1'b1 || i_done !== 1'b1 || i_rdata !== 32'h99)
            begin n_fail++; $display("FAIL spur_fetch: got ok=%b done=%b rdata=%h expected 1 1 99", ok, i_done, i_rdata); end
        i_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait;
        logic ok = 1'b0;
        d_req = 1'b1; d_addr = 32'h8000; d_we = 4'h0; mem_req_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (mem_req_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rwait_timeout: got %b expected 1", ok); end
        @(negedge clk);
        mem_req_ready = 1'b0;
        n_checks++; if (mem_req_valid !== 1'b0 || d_done !== 1'b0 || mem_req_addr !== 32'h8000)
            begin n_fail++; $display("FAIL rwait_inwait: got v=%b d=%b a=%h expected 0 0 8000", mem_req_valid, d_done, mem_req_addr); end
        #2;
        reset_n = 1'b0; d_req = 1'b0;
        #1;
        n_checks++; if ({mem_req_valid, i_done, d_done, stall} !== 4'b0000)
            begin n_fail++; $display("FAIL rwait_ctrl: got v=%b i=%b d=%b st=%b expected 0000", mem_req_valid, i_done, d_done, stall); end
        n_checks++; if (mem_req_addr !== 32'h0 || mem_req_we !== 4'h0 || mem_req_wdata !== 32'h0)
            begin n_fail++; $display("FAIL rwait_fields: got a=%h we=%h wd=%h expected 0", mem_req_addr, mem_req_we, mem_req_wdata); end
        n_checks++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0)
            begin n_fail++; $display("FAIL rwait_rdata: got i=%h d=%h expected 0 0", i_rdata, d_rdata); end
        mem_resp_valid = 1'b1; mem_resp_data = 32'h5555_5555;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({i_done, d_done, mem_req_valid} !== 3'b000)
            begin n_fail++; $display("FAIL rwait_release: got i=%b d=%b v=%b expected 000", i_done, d_done, mem_req_valid); end
    endtask

    initial begin
        test_reset();
        test_single_fetch("fetch");
        test_d_priority();
        test_starvation();
        test_ready_hold();
        test_spurious_resp();
        test_reset_in_wait();
        test_single_fetch("refetch");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
